// File: rtl/regfile16x8_sequencer.sv
// Command sequencer for the 16-bit x 8-entry register file.
// Accepts one read/write command at a time. Holds rf_enable with stable select/data for
// HOLD_CYCLES cycles, then inserts one idle GAP cycle. Returns the response over a
// valid/ready handshake. Every output is a flop, so cmd_* and rsp_ready never reach an
// output combinationally.
module regfile16x8_sequencer #(
    parameter int unsigned HOLD_CYCLES = 3  // legal range 2..15
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [2:0]  cmd_select,
    input  logic [15:0] cmd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_write,
    output logic [15:0] rsp_data,
    output logic        rf_enable,
    output logic        rf_write,
    output logic [2:0]  rf_select,
    output logic [15:0] rf_data,
    input  logic [15:0] rf_rdata
);

    typedef enum logic [1:0] {StIdle, StDrive, StGap, StResp} state_e;

    localparam logic [3:0] HoldLoad = 4'(HOLD_CYCLES - 1);

    state_e     state_q;
    logic [3:0] hold_cnt_q;

    // Sequencer FSM. The rf_* registers double as the command registers: they are loaded
    // on accept and left untouched until the next accept, which keeps select/data stable
    // through DRIVE and GAP.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= StIdle;
            hold_cnt_q <= 4'd0;
            cmd_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_write  <= 1'b0;
            rsp_data   <= 16'h0000;
            rf_enable  <= 1'b0;
            rf_write   <= 1'b0;
            rf_select  <= 3'd0;
            rf_data    <= 16'h0000;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready  <= 1'b0;
                        rf_enable  <= 1'b1;
                        rf_write   <= cmd_write;
                        rf_select  <= cmd_select;
                        // Reads present zero on the write-data bus.
                        rf_data    <= cmd_write ? cmd_data : 16'h0000;
                        hold_cnt_q <= HoldLoad;
                        state_q    <= StDrive;
                    end
                end
                StDrive: begin
                    if (hold_cnt_q == 4'd0) begin
                        // Last enabled cycle: read data is settled at this edge.
                        rsp_write <= rf_write;
                        rsp_data  <= rf_write ? rf_data : rf_rdata;
                        rf_enable <= 1'b0;
                        rf_write  <= 1'b0;
                        state_q   <= StGap;
                    end else begin
                        hold_cnt_q <= hold_cnt_q - 4'd1;
                    end
                end
                StGap: begin
                    rsp_valid <= 1'b1;
                    state_q   <= StResp;
                end
                StResp: begin
                    if (rsp_valid && rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state_q   <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile16x8_sequencer.sv
// Scoreboard bench for regfile16x8_sequencer: directed commands push expected responses,
// a negedge monitor pops and compares them and checks latency, stability and ordering.
// Two extra instances (HOLD_CYCLES 2 and 15) are used for hold/gap timing checks.
module tb_regfile16x8_sequencer;

    typedef struct packed {
        logic        w;
        logic [15:0] d;
    } exp_t;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [2:0]  cmd_select;
    logic [15:0] cmd_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_write;
    logic [15:0] rsp_data;
    logic        rf_enable;
    logic        rf_write;
    logic [2:0]  rf_select;
    logic [15:0] rf_data;
    logic [15:0] rf_rdata;

    // Hold-timing instances: index 0 -> HOLD_CYCLES 2, index 1 -> HOLD_CYCLES 15.
    logic        h_cv  [2];
    logic        h_cw  [2];
    logic [2:0]  h_cs  [2];
    logic [15:0] h_cd  [2];
    logic        h_cr  [2];
    logic        h_rv  [2];
    logic        h_rw  [2];
    logic [15:0] h_rd  [2];
    logic        h_en  [2];
    logic        h_wr  [2];
    logic [2:0]  h_sel [2];
    logic [15:0] h_dat [2];

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t exp_q[$];
    int   acc_q[$];
    int   acc_log[$];

    // Monitor state
    bit          prev_vld = 1'b0;
    bit          stall    = 1'b0;
    logic        held_w;
    logic [15:0] held_d;
    exp_t        e_m;
    int          c_m;

    // Behavioural register file: register 0 reads as zero.
    logic [15:0] rf_mem [8] = '{default: 16'h0000};

    always #5 aclk = ~aclk;

    always @(posedge aclk) cyc <= cyc + 1;

    always @(posedge aclk) begin
        if (rf_enable && rf_write && rf_select != 3'd0) rf_mem[rf_select] <= rf_data;
    end

    assign rf_rdata = (rf_select == 3'd0) ? 16'h0000 : rf_mem[rf_select];

    regfile16x8_sequencer #(.HOLD_CYCLES(3)) u_dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_select (cmd_select),
        .cmd_data   (cmd_data),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_write  (rsp_write),
        .rsp_data   (rsp_data),
        .rf_enable  (rf_enable),
        .rf_write   (rf_write),
        .rf_select  (rf_select),
        .rf_data    (rf_data),
        .rf_rdata   (rf_rdata)
    );

    for (genvar g = 0; g < 2; g++) begin : g_hold
        localparam int unsigned HH = (g == 0) ? 2 : 15;
        regfile16x8_sequencer #(.HOLD_CYCLES(HH)) u_hold (
            .aclk       (aclk),
            .aresetn    (aresetn),
            .cmd_valid  (h_cv[g]),
            .cmd_ready  (h_cr[g]),
            .cmd_write  (h_cw[g]),
            .cmd_select (h_cs[g]),
            .cmd_data   (h_cd[g]),
            .rsp_valid  (h_rv[g]),
            .rsp_ready  (1'b1),
            .rsp_write  (h_rw[g]),
            .rsp_data   (h_rd[g]),
            .rf_enable  (h_en[g]),
            .rf_write   (h_wr[g]),
            .rf_select  (h_sel[g]),
            .rf_data    (h_dat[g]),
            .rf_rdata   (16'h0000)
        );
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor / scoreboard, sampled on the falling edge.
    always @(negedge aclk) begin
        if (!aresetn) begin
            acc_q.delete();
            prev_vld = 1'b0;
            stall    = 1'b0;
        end else begin
            if (cmd_valid && cmd_ready) begin
                acc_q.push_back(cyc);
                acc_log.push_back(cyc);
            end
            if (rsp_valid) chk("cmd_ready_low_in_resp", cmd_ready, 1'b0);
            if (rsp_valid && !prev_vld) begin
                if (acc_q.size() == 0) begin
                    chk("rsp_without_accept", 1'b1, 1'b0);
                end else begin
                    c_m = acc_q.pop_front();
                    chk("rsp_latency", cyc - c_m, 5);
                end
            end
            if (stall) begin
                chk("stall_rsp_valid", rsp_valid, 1'b1);
                chk("stall_rsp_write", rsp_write, held_w);
                chk("stall_rsp_data", rsp_data, held_d);
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 1'b1, 1'b0);
                end else begin
                    e_m = exp_q.pop_front();
                    chk("rsp_write", rsp_write, e_m.w);
                    chk("rsp_data", rsp_data, e_m.d);
                end
            end
            stall    = rsp_valid && !rsp_ready;
            held_w   = rsp_write;
            held_d   = rsp_data;
            prev_vld = rsp_valid;
        end
    end

    task automatic present(input logic w, input logic [2:0] s, input logic [15:0] d,
                           input logic [15:0] e, input bit expect_rsp);
        cmd_valid  = 1'b1;
        cmd_write  = w;
        cmd_select = s;
        cmd_data   = d;
        if (expect_rsp) exp_q.push_back('{w: w, d: e});
    endtask

    task automatic wait_accept();
        int n = 0;
        while (!cmd_ready && n < 100) begin
            @(posedge aclk); #1;
            n++;
        end
        if (n >= 100) chk("accept_timeout", 1'b0, 1'b1);
        @(posedge aclk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic send(input logic w, input logic [2:0] s, input logic [15:0] d,
                        input logic [15:0] e);
        present(w, s, d, e, 1'b1);
        wait_accept();
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge aclk); #1;
            n++;
        end
        if (n >= 500) chk("drain_timeout", 1'b0, 1'b1);
        repeat (2) begin
            @(posedge aclk); #1;
        end
    endtask

    task automatic hold_test(input int k, input int h);
        logic [2:0]  sel0;
        logic [15:0] dat0;
        int n = 0;
        chk("hold_cmd_ready_idle", h_cr[k], 1'b1);
        h_cv[k] = 1'b1;
        h_cw[k] = 1'b1;
        h_cs[k] = 3'd6;
        h_cd[k] = 16'h5A5A;
        @(posedge aclk); #1;
        h_cv[k] = 1'b0;
        @(negedge aclk);
        sel0 = h_sel[k];
        dat0 = h_dat[k];
        chk("hold_sel_value", sel0, 3'd6);
        chk("hold_dat_value", dat0, 16'h5A5A);
        while (h_en[k] && n < 40) begin
            chk("hold_sel_stable", h_sel[k], sel0);
            chk("hold_dat_stable", h_dat[k], dat0);
            chk("hold_rf_write", h_wr[k], 1'b1);
            n++;
            @(negedge aclk);
        end
        chk("hold_enable_len", n, h);
        chk("gap_enable", h_en[k], 1'b0);
        chk("gap_write", h_wr[k], 1'b0);
        chk("gap_rsp_valid", h_rv[k], 1'b0);
        chk("gap_sel_held", h_sel[k], 3'd6);
        @(negedge aclk);
        chk("hold_rsp_valid", h_rv[k], 1'b1);
        chk("hold_rsp_write", h_rw[k], 1'b1);
        chk("hold_rsp_data", h_rd[k], 16'h5A5A);
        @(posedge aclk); #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        aresetn    = 1'b0;
        cmd_valid  = 1'b0;
        cmd_write  = 1'b0;
        cmd_select = 3'd0;
        cmd_data   = 16'h0000;
        rsp_ready  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            h_cv[i] = 1'b0;
            h_cw[i] = 1'b0;
            h_cs[i] = 3'd0;
            h_cd[i] = 16'h0000;
        end
        repeat (3) @(posedge aclk);
        #1;
        chk("reset_cmd_ready", cmd_ready, 1'b1);
        chk("reset_rsp_valid", rsp_valid, 1'b0);
        chk("reset_rsp_write", rsp_write, 1'b0);
        chk("reset_rsp_data", rsp_data, 16'h0000);
        chk("reset_rf_enable", rf_enable, 1'b0);
        chk("reset_rf_write", rf_write, 1'b0);
        chk("reset_rf_select", rf_select, 3'd0);
        chk("reset_rf_data", rf_data, 16'h0000);
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk); #1;

        // Write then read register 5.
        send(1'b1, 3'd5, 16'hBEEF, 16'hBEEF);
        send(1'b0, 3'd5, 16'hFFFF, 16'hBEEF);
        drain();

        // Register 0 reads back zero.
        send(1'b1, 3'd0, 16'h1234, 16'h1234);
        send(1'b0, 3'd0, 16'h0000, 16'h0000);
        drain();

        // Backpressure: stall the first response while a second command waits.
        rsp_ready = 1'b0;
        send(1'b1, 3'd7, 16'h0F0F, 16'h0F0F);
        present(1'b0, 3'd7, 16'h0000, 16'h0F0F, 1'b1);
        begin
            int n = 0;
            while (!rsp_valid && n < 50) begin
                @(posedge aclk); #1;
                n++;
            end
            if (n >= 50) chk("bp_rsp_timeout", 1'b0, 1'b1);
        end
        repeat (10) begin
            chk("bp_cmd_ready", cmd_ready, 1'b0);
            @(posedge aclk); #1;
        end
        rsp_ready = 1'b1;
        wait_accept();
        drain();

        // Reset in the middle of a write: nothing comes back.
        present(1'b1, 3'd3, 16'hAAAA, 16'h0000, 1'b0);
        wait_accept();
        @(posedge aclk); #1;
        chk("abort_mid_drive", rf_enable, 1'b1);
        #2;
        aresetn = 1'b0;
        #1;
        chk("abort_rf_enable", rf_enable, 1'b0);
        chk("abort_rsp_valid", rsp_valid, 1'b0);
        chk("abort_cmd_ready", cmd_ready, 1'b1);
        @(negedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk); #1;
        chk("post_reset_cmd_ready", cmd_ready, 1'b1);
        repeat (15) begin
            @(posedge aclk); #1;
        end

        // Sweep all indices back to back, then read them all back.
        acc_log.delete();
        for (int i = 0; i < 8; i++) begin
            logic [15:0] v;
            v = 16'(16'h1111 * (i + 1));
            send(1'b1, 3'(i), v, v);
        end
        for (int i = 0; i < 8; i++) begin
            logic [15:0] v;
            v = (i == 0) ? 16'h0000 : 16'(16'h1111 * (i + 1));
            send(1'b0, 3'(i), 16'h0000, v);
        end
        drain();
        chk("sweep_accept_count", acc_log.size(), 16);
        for (int i = 1; i < acc_log.size(); i++) begin
            chk("sweep_period", acc_log[i] - acc_log[i - 1], 6);
        end

        // Hold and gap timing at both extremes.
        hold_test(0, 2);
        hold_test(1, 15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
